// File: rtl/ascon_inv_sbox_layer_pkg.sv
// Shared types, constants and helpers for the iterative inverse Ascon
// substitution layer.
package ascon_inv_sbox_layer_pkg;

    localparam int WORDS   = 5;
    localparam int WORD_W  = 64;
    localparam int STATE_W = WORDS * WORD_W;

    // Five 64-bit words. Entry 0 is x0, which is the most significant word
    // of the packed 320-bit vector.
    typedef logic [0:WORDS-1][WORD_W-1:0] type_state;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_fsm;

    // Inverse Ascon S-box. Entry 0 is the leftmost value in the list.
    localparam logic [0:31][4:0] INV_SBOX_TABLE = {
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    // Split a packed {x0,x1,x2,x3,x4} vector into words.
    function automatic type_state unpack_state(input logic [STATE_W-1:0] vec);
        type_state st;
        for (int i = 0; i < WORDS; i++) begin
            st[i] = vec[STATE_W-1-i*WORD_W -: WORD_W];
        end
        return st;
    endfunction

    // Join words back into a packed {x0,x1,x2,x3,x4} vector.
    function automatic logic [STATE_W-1:0] pack_state(input type_state st);
        logic [STATE_W-1:0] vec;
        vec = '0;
        for (int i = 0; i < WORDS; i++) begin
            vec[STATE_W-1-i*WORD_W -: WORD_W] = st[i];
        end
        return vec;
    endfunction

    // Columns per cycle must divide the 64-bit word into a power-of-two
    // number of slices.
    function automatic bit cols_legal(input int cols);
        return (cols == 1) || (cols == 2) || (cols == 4) || (cols == 8) ||
               (cols == 16) || (cols == 32) || (cols == 64);
    endfunction

endpackage

// File: rtl/ascon_inv_sbox_layer_if.sv
// Handshake and data bundle between a producer/consumer and the inverse
// substitution layer.
interface ascon_inv_sbox_layer_if
    import ascon_inv_sbox_layer_pkg::*;
    ();

    logic               in_valid_i;
    logic               in_ready_o;
    logic [STATE_W-1:0] state_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [STATE_W-1:0] state_o;
    logic               busy_o;

    // Side that supplies states and consumes results.
    modport master (
        output in_valid_i,
        input  in_ready_o,
        output state_i,
        input  out_valid_o,
        output out_ready_i,
        input  state_o,
        input  busy_o
    );

    // The inverse substitution layer itself.
    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  state_i,
        output out_valid_o,
        input  out_ready_i,
        output state_o,
        output busy_o
    );

endinterface

// File: rtl/ascon_inv_sbox_layer_inv_sbox.sv
// Single-column inverse Ascon S-box: purely combinational table lookup.
module inv_sbox
    import ascon_inv_sbox_layer_pkg::*;
(
    input  logic [4:0] inv_sbox_i,
    output logic [4:0] inv_sbox_o
);

    assign inv_sbox_o = INV_SBOX_TABLE[inv_sbox_i];

endmodule

// File: rtl/ascon_inv_sbox_layer.sv
// Iterative inverse Ascon substitution layer. Inverts COLS_PER_CYCLE
// columns per clock by substituting the low columns of every word and then
// rotating all words right, so after NB_ITER cycles each column has been
// visited once and the words are back in their original bit order.
module ascon_inv_sbox_layer
    import ascon_inv_sbox_layer_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input logic                  clock_i,
    input logic                  reset_i,
    ascon_inv_sbox_layer_if.slave bus
);

    localparam int NB_ITER = WORD_W / COLS_PER_CYCLE;
    localparam int CNT_W   = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;

    if (!cols_legal(COLS_PER_CYCLE)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    type_fsm            state_q;
    type_fsm            state_d;
    type_state          work_q;
    type_state          work_d;
    type_state          sub_words;
    logic [CNT_W-1:0]   cnt_q;
    logic [STATE_W-1:0] result_q;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic               accept;
    logic               last_iter;
    logic [4:0]         col_in  [COLS_PER_CYCLE];
    logic [4:0]         col_out [COLS_PER_CYCLE];

    assign accept    = bus.in_valid_i && in_ready;
    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(NB_ITER - 1));

    // Column k gathers bit k of every word, x0 as the column MSB.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_in[k] = {work_q[0][k], work_q[1][k], work_q[2][k],
                            work_q[3][k], work_q[4][k]};

        inv_sbox u_inv_sbox (
            .inv_sbox_i (col_in[k]),
            .inv_sbox_o (col_out[k])
        );
    end

    // Next working state: substituted low columns land in the top bits,
    // which is the same as writing them back and rotating right.
    always_comb begin
        // NOTE: every variable gets a default before any branch or loop so
        // no path leaves it unassigned and no latch is inferred.
        sub_words = '0;
        work_d    = work_q;
        for (int i = 0; i < WORDS; i++) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                sub_words[i][k] = col_out[k][4-i];
            end
            work_d[i] = (work_q[i] >> COLS_PER_CYCLE) |
                        (sub_words[i] << (WORD_W - COLS_PER_CYCLE));
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Working register: loaded on accept, stepped once per RUN cycle.
    always_ff @(posedge clock_i) begin
        // NOTE: the working register carries no reset; it is always loaded
        // on accept before it is read, so resetting 320 flops buys nothing.
        if (accept) begin
            work_q <= unpack_state(bus.state_i);
        end else if (state_q == RUN) begin
            work_q <= work_d;
        end
    end

    // Iteration counter and registered result.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_iter) begin
                result_q <= pack_state(work_d);
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.busy_o      = busy;
    assign bus.state_o     = result_q;

endmodule

// File: tb/tb_ascon_inv_sbox_layer.sv
// Scoreboard bench for the inverse Ascon substitution layer. Three
// instances (8, 1 and 64 columns per cycle) share clock and reset; inputs
// are forward-substituted random states and the expected result is the
// original state.
module tb_ascon_inv_sbox_layer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic [319:0] st_in     [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [319:0] st_out    [3];

    ascon_inv_sbox_layer_if bus8  ();
    ascon_inv_sbox_layer_if bus1  ();
    ascon_inv_sbox_layer_if bus64 ();

    assign bus8.in_valid_i  = in_valid[0];
    assign bus8.state_i     = st_in[0];
    assign bus8.out_ready_i = out_ready[0];
    assign in_ready[0]      = bus8.in_ready_o;
    assign out_valid[0]     = bus8.out_valid_o;
    assign busy[0]          = bus8.busy_o;
    assign st_out[0]        = bus8.state_o;

    assign bus1.in_valid_i  = in_valid[1];
    assign bus1.state_i     = st_in[1];
    assign bus1.out_ready_i = out_ready[1];
    assign in_ready[1]      = bus1.in_ready_o;
    assign out_valid[1]     = bus1.out_valid_o;
    assign busy[1]          = bus1.busy_o;
    assign st_out[1]        = bus1.state_o;

    assign bus64.in_valid_i  = in_valid[2];
    assign bus64.state_i     = st_in[2];
    assign bus64.out_ready_i = out_ready[2];
    assign in_ready[2]       = bus64.in_ready_o;
    assign out_valid[2]      = bus64.out_valid_o;
    assign busy[2]           = bus64.busy_o;
    assign st_out[2]         = bus64.state_o;

    ascon_inv_sbox_layer #(.COLS_PER_CYCLE(8)) dut8 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus8)
    );

    ascon_inv_sbox_layer #(.COLS_PER_CYCLE(1)) dut1 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus1)
    );

    ascon_inv_sbox_layer #(.COLS_PER_CYCLE(64)) dut64 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus64)
    );

    // Forward Ascon S-box; the reference model only ever goes forward and
    // relies on the round trip to check the inverse.
    logic [4:0] fwd_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    int n_checks = 0;
    int n_errors = 0;

    logic [319:0] q0 [$];
    logic [319:0] q1 [$];
    logic [319:0] q2 [$];

    localparam logic [63:0] ONES = {64{1'b1}};
    localparam logic [63:0] ZERO = 64'd0;
    localparam logic [63:0] TOP  = {1'b1, 63'd0};

    task automatic check(input string name, input logic [319:0] act,
                         input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nb_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 64;
            default: return 1;
        endcase
    endfunction

    // Forward substitution layer applied column by column.
    function automatic logic [319:0] fwd_layer(input logic [319:0] s);
        logic [319:0] r;
        logic [4:0]   v;
        logic [4:0]   y;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
            y = fwd_tbl[v];
            {r[256+j], r[192+j], r[128+j], r[64+j], r[j]} = y;
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void push(input int sel, input logic [319:0] v);
        case (sel)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int pending();
        return q0.size() + q1.size() + q2.size();
    endfunction

    // Monitor: pops the scoreboard on every completed output handshake.
    initial begin
        logic [319:0] exp;
        int           sz;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst === 1'b0 && out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                    case (k)
                        0:       sz = q0.size();
                        1:       sz = q1.size();
                        default: sz = q2.size();
                    endcase
                    if (sz == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output dut%0d: got %0h expected none", k, st_out[k]);
                    end else begin
                        case (k)
                            0:       exp = q0.pop_front();
                            1:       exp = q1.pop_front();
                            default: exp = q2.pop_front();
                        endcase
                        check($sformatf("result_dut%0d", k), st_out[k], exp);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int sel);
        int n = 0;
        while (in_ready[sel] !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout dut%0d: got in_ready=0 expected 1", sel);
        end
    endtask

    // Sends one state, queues its expected result, returns once out_valid
    // is seen; the latency counts the accept edge as cycle 1.
    task automatic run_one(input int sel, input logic [319:0] data,
                           input logic [319:0] exp, input bit check_lat);
        int lat;
        wait_ready(sel);
        push(sel, exp);
        st_in[sel]    = data;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        lat = 1;
        while (out_valid[sel] !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (check_lat || lat == 300) begin
            check($sformatf("latency_dut%0d", sel), 320'(lat), 320'(nb_of(sel) + 1));
        end
    endtask

    initial begin
        logic [319:0] r;
        logic [319:0] held;
        bit           seen;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b1;
            st_in[k]     = rand_state();
            out_ready[k] = 1'b1;
        end

        // Reset held with in_valid asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_flags_dut%0d", k),
                  320'({in_ready[k], out_valid[k], busy[k]}), 320'(3'b100));
            check($sformatf("reset_state_dut%0d", k), st_out[k], '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("no_accept_dut%0d", k),
                  320'({in_ready[k], out_valid[k], busy[k]}), 320'(3'b100));
        end

        // Fixed columns: 0x04 everywhere inverts to 0, 0x0b to 0x01.
        run_one(0, {ZERO, ZERO, ONES, ZERO, ZERO}, '0, 1'b1);
        run_one(0, {ZERO, ONES, ZERO, ONES, ONES}, {ZERO, ZERO, ZERO, ZERO, ONES}, 1'b1);

        // Column mapping: column 63 = 0x1f -> 0x02, the rest 0x04 -> 0.
        run_one(0, {TOP, TOP, ONES, TOP, TOP}, {ZERO, ZERO, ZERO, TOP, ZERO}, 1'b0);

        // Round trip through the forward layer on every instance.
        for (int sel = 0; sel < 3; sel++) begin
            for (int n = 0; n < 64; n++) begin
                r = rand_state();
                run_one(sel, fwd_layer(r), r, n < 3);
            end
        end

        // Backpressure: result must hold with no new input accepted.
        out_ready[0] = 1'b0;
        r = rand_state();
        run_one(0, fwd_layer(r), r, 1'b0);
        held = st_out[0];
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("hold_state", st_out[0], held);
            check("hold_flags", 320'({out_valid[0], in_ready[0], busy[0]}), 320'(3'b100));
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", 320'({in_ready[0], out_valid[0], busy[0]}), 320'(3'b100));

        // Reset during the fourth RUN cycle discards the state.
        wait_ready(0);
        st_in[0]    = rand_state();
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_run_busy", 320'(busy[0]), 320'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_run_reset_idle", 320'({in_ready[0], out_valid[0], busy[0]}), 320'(3'b100));
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        check("no_valid_after_reset", 320'(seen), 320'(0));
        r = rand_state();
        run_one(0, fwd_layer(r), r, 1'b1);

        // Let the monitor drain the scoreboard.
        for (int n = 0; n < 500 && pending() != 0; n++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 320'(pending()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_inv_sbox_layer.md
Name: ascon_inv_sbox_layer

Overview:
- Iterative inverse of the Ascon substitution layer: maps a 320-bit state (five 64-bit words x0..x4) back through S^-1 column by column.
- Each column j is {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB.
- Used by decryption-side analysis and by self-checking benches that round-trip the forward sbox layer.
- Processes COLS_PER_CYCLE columns per clock, with valid/ready handshakes on input and output.

Parameters:
- COLS_PER_CYCLE, 8, columns inverted per cycle; legal values 1, 2, 4, 8, 16, 32, 64; any other value is an elaboration error.
- NB_ITER, 64/COLS_PER_CYCLE, derived iteration count; not overridable.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input state valid.
- in_ready_o  out  1  block can accept a state.
- state_i  in  320  {x0,x1,x2,x3,x4}; x0 in bits [319:256].
- out_valid_o  out  1  result valid, held until accepted.
- out_ready_i  in  1  downstream accepts result.
- state_o  out  320  inverted state, same packing as state_i.
- busy_o  out  1  high while in RUN.

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0. Counter and FSM go to IDLE. Reset mid-RUN or mid-DONE discards the state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: latch state_i into the working register, clear the counter, go to RUN.
- RUN:
  - in_ready_o=0, busy_o=1.
  - Each cycle, for every word: take the low COLS_PER_CYCLE bits of all five words, apply inv_sbox per column, write the results back, then rotate each word right by COLS_PER_CYCLE.
  - After NB_ITER cycles every word is back in original bit order.
  - Counter runs 0..NB_ITER-1. At NB_ITER-1 go to DONE.
- DONE:
  - out_valid_o=1; state_o holds the result, stable while out_valid_o=1 and out_ready_i=0.
  - On out_ready_i: out_valid_o drops, go to IDLE.
  - No new input is accepted in the same cycle (in_ready_o=0 in DONE).
- Latency: input accept edge to out_valid_o high is NB_ITER+1 cycles. Default is 9 cycles.
- Throughput: one state per NB_ITER+2 cycles with out_ready_i tied high.
- state_o is registered and meaningful only while out_valid_o=1. Between results it holds the last value.
- in_valid_i is ignored outside IDLE. out_ready_i is ignored outside DONE.
- S^-1 table, index 0x00..0x1f: 14 1a 07 0d 00 09 0e 12 0a 06 1d 01 19 15 13 1e 18 16 0b 11 03 05 1c 1f 17 1b 04 08 0f 0c 10 02.

Decomposition:
- ascon_pkg:
  - typedef type_state as a 5-entry array of 64-bit words.
  - typedef for the FSM state enum.
  - constant INV_SBOX_TABLE (32x5 bits).
  - functions to pack/unpack between the 320-bit vector and type_state.
- Sub-module inv_sbox: combinational 5-bit in, 5-bit out, ports inv_sbox_i/inv_sbox_o.
  - Instantiated COLS_PER_CYCLE times via generate.
  - Independently testable against the forward sbox.

Test Plan:
1. Reset held 3 cycles with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0, no accept.
2. State with every column 0x04 (x0=x1=x3=x4=0, x2=all ones) -> after 9 cycles state_o=0. State with every column 0x0b (x0=x2=0, x1=x3=x4=all ones) -> x4=all ones, others 0.
3. Round trip: 64 random states through the forward sbox layer model, then this block -> state_o equals the original each time. Repeat for COLS_PER_CYCLE=1 (latency 65) and 64 (latency 2).
4. Backpressure: out_ready_i=0 for 20 cycles after out_valid_o -> state_o stable, in_ready_o=0. Release -> IDLE the next cycle.
5. Reset asserted at RUN cycle 4 -> next cycle IDLE, out_valid_o never rises. A following state completes correctly.
6. Column mapping: only column 63 = 0x1f (bit 63 of all words set), all other columns 0x04 -> column 63 becomes 0x02 (x3[63]=1), others 0x00.
